mdu: RTL and testbench

Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in the EX stage directly downstream of the general register file. It consumes the two register-file read operands (after forwarding) and produces the HI/LO special registers read by mfhi/mflo. It raises `busy` while an operation is in flight so the hazard unit can stall dependent MD instructions in ID.

---
 rtl/mdu.sv | 123 ++++++++++++
 tb/tb_mdu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit producing the HI/LO registers for mfhi/mflo.
// Results are computed at issue and released after a fixed busy window.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   tmphi;
  logic [31:0]   tmplo;
  logic          tmpvalid;

  logic [63:0]   sprod;
  logic [63:0]   uprod;
  logic [31:0]   divisor;
  logic [31:0]   sq;
  logic [31:0]   sr;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic          dz;
  logic          ovf;
  logic [63:0]   result;
  logic          resvalid;
  logic          isdiv;

  // Divide-by-zero and INT_MIN/-1 both divide by 1 so the divider never traps;
  // the overflow case is patched explicitly and divide-by-zero discards its result.
  always_comb begin
    dz       = (b == 32'd0);
    ovf      = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    divisor  = (dz || ovf) ? 32'd1 : b;
    sprod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod    = {32'd0, a} * {32'd0, b};
    sq       = $signed(a) / $signed(divisor);
    sr       = $signed(a) % $signed(divisor);
    uq       = a / divisor;
    ur       = a % divisor;
    result   = 64'd0;
    resvalid = 1'b1;
    isdiv    = 1'b0;
    case (op)
      3'd0: result = sprod;
      3'd1: result = uprod;
      3'd2: begin
        isdiv    = 1'b1;
        resvalid = !dz;
        result   = ovf ? {32'd0, 32'h8000_0000} : {sr, sq};
      end
      3'd3: begin
        isdiv    = 1'b1;
        resvalid = !dz;
        result   = {ur, uq};
      end
      default: resvalid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      cnt      <= '0;
      tmphi    <= 32'd0;
      tmplo    <= 32'd0;
      tmpvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                tmphi    <= result[63:32];
                tmplo    <= result[31:0];
                tmpvalid <= resvalid;
                cnt      <= isdiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state    <= RUN;
                busy     <= 1'b1;
              end
              3'd4: hi <= a;
              3'd5: lo <= a;
              default: ;
            endcase
          end
        end
        // Any start seen here is dropped; upstream is expected to stall on busy.
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (tmpvalid) begin
              hi <= tmphi;
              lo <= tmplo;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the driver predicts HI/LO from plain arithmetic,
// a negedge monitor pops each prediction when it falls due and compares.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] prehi;
    logic [31:0] prelo;
    int          due;
    int          busyexp;
  } exp_t;

  exp_t        sbq[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] refhi      = 32'd0;
  logic [31:0] reflo      = 32'd0;
  int          readyCyc   = 0;
  int          lastStart  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: what HI/LO must hold once the operation has completed.
  function automatic logic [63:0] mdRef(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] ch, input logic [31:0] cl);
    int sx, sy, q, r;
    longint p;
    logic [63:0] up;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin
        p = longint'(sx) * longint'(sy);
        return 64'(p);
      end
      3'd1: begin
        up = 64'(x) * 64'(y);
        return up;
      end
      3'd2: begin
        if (y == 32'd0) return {ch, cl};
        if (x == 32'h8000_0000 && y == 32'hffff_ffff) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx - q * sy;
        return {r, q};
      end
      3'd3: begin
        if (y == 32'd0) return {ch, cl};
        return {x - (x / y) * y, x / y};
      end
      3'd4: return {x, cl};
      3'd5: return {ch, x};
      default: return {ch, cl};
    endcase
  endfunction

  // Monitor
  int   busyCount = 0;
  bit   unstable  = 1'b0;
  exp_t monE;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busyCount++;
      if (sbq.size() > 0 && (hi !== sbq[0].prehi || lo !== sbq[0].prelo)) unstable = 1'b1;
    end
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      monE = sbq.pop_front();
      if (monE.due < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s missed: got cycle %0d expected cycle %0d", monE.name, cyc, monE.due);
      end else begin
        checkOutput({monE.name, " hi"}, hi, monE.hi);
        checkOutput({monE.name, " lo"}, lo, monE.lo);
        checkOutput({monE.name, " busy"}, {31'd0, busy}, 32'd0);
        checkOutput({monE.name, " busycycles"}, 32'(busyCount), 32'(monE.busyexp));
        checkOutput({monE.name, " stable"}, {31'd0, unstable}, 32'd0);
      end
      busyCount = 0;
      unstable  = 1'b0;
    end
  end

  task automatic advanceTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
    logic [63:0] r;
    exp_t e;
    int   n;
    advanceTo(readyCyc);
    op = o; a = x; b = y; start = 1'b1;
    lastStart = cyc;
    r = mdRef(o, x, y, refhi, reflo);
    e.name  = name;
    e.prehi = refhi;
    e.prelo = reflo;
    e.hi    = r[63:32];
    e.lo    = r[31:0];
    if (o <= 3'd3) begin
      n         = (o < 3'd2) ? MC : DC;
      e.due     = lastStart + n + 1;
      e.busyexp = n;
      readyCyc  = lastStart + n + 1;
    end else begin
      e.due     = lastStart + 1;
      e.busyexp = 0;
      readyCyc  = lastStart + 1;
    end
    sbq.push_back(e);
    refhi = e.hi;
    reflo = e.lo;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // A start pulse during busy cycle k of the last operation; the model ignores it.
  task automatic pulseIgnored(input logic [2:0] o, input logic [31:0] x, input int k);
    advanceTo(lastStart + k);
    op = o; a = x; b = $urandom; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reset during busy cycle k; everything pending is replaced by the all-zero state.
  task automatic applyReset(input int k);
    exp_t e;
    advanceTo(lastStart + k);
    reset = 1'b1;
    e.name    = "midreset";
    e.prehi   = (sbq.size() > 0) ? sbq[0].prehi : refhi;
    e.prelo   = (sbq.size() > 0) ? sbq[0].prelo : reflo;
    e.hi      = 32'd0;
    e.lo      = 32'd0;
    e.due     = lastStart + k + 1;
    e.busyexp = k;
    sbq.delete();
    sbq.push_back(e);
    refhi = 32'd0;
    reflo = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    readyCyc = cyc;
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          guard;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    e.name = "reset"; e.hi = 32'd0; e.lo = 32'd0; e.prehi = 32'd0; e.prelo = 32'd0;
    e.due = cyc; e.busyexp = 0;
    sbq.push_back(e);
    readyCyc = cyc + 1;

    applyStimulus(3'd0, 32'hffff_ffff, 32'd2, "mult");
    applyStimulus(3'd1, 32'hffff_ffff, 32'd2, "multu");
    applyStimulus(3'd2, 32'hffff_fff9, 32'd2, "div");
    applyStimulus(3'd3, 32'd7, 32'd2, "divu");
    applyStimulus(3'd4, 32'h11, 32'd0, "mthi");
    applyStimulus(3'd5, 32'h22, 32'd0, "mtlo");
    applyStimulus(3'd2, 32'd5, 32'd0, "divzero");
    applyStimulus(3'd3, 32'd9, 32'd0, "divuzero");
    applyStimulus(3'd2, 32'h8000_0000, 32'hffff_ffff, "divovf");
    applyStimulus(3'd3, 32'd7, 32'd2, "divu_mthi");
    pulseIgnored(3'd4, 32'hAA, 3);
    applyStimulus(3'd0, 32'd3, 32'd4, "mult_reset");
    applyReset(4);
    applyStimulus(3'd0, 32'hffff_0000, 32'h0001_2345, "mult_after_reset");
    applyStimulus(3'd6, 32'h1234, 32'd5, "nop");

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = randOperand();
      ry = randOperand();
      applyStimulus(ro, rx, ry, "random");
      if (ro <= 3'd3) begin
        case ($urandom_range(0, 5))
          0: pulseIgnored(3'($urandom_range(0, 7)), $urandom, $urandom_range(1, (ro < 3'd2) ? MC : DC));
          1: applyReset($urandom_range(1, (ro < 3'd2) ? MC : DC));
          default: ;
        endcase
      end
    end

    guard = 0;
    while (sbq.size() > 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sbq.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
